// File: rtl/pll_drp_pkg.sv
// Shared types, constants and divider encoding for the
// PLLE2 DRP reconfiguration controller.
package pll_drp_pkg;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_CHECK     = 4'd1;
  localparam logic [3:0] S_HOLD      = 4'd2;
  localparam logic [3:0] S_RD        = 4'd3;
  localparam logic [3:0] S_RD_WAIT   = 4'd4;
  localparam logic [3:0] S_WR        = 4'd5;
  localparam logic [3:0] S_WR_WAIT   = 4'd6;
  localparam logic [3:0] S_NEXT      = 4'd7;
  localparam logic [3:0] S_RELEASE   = 4'd8;
  localparam logic [3:0] S_LOCK_WAIT = 4'd9;
  localparam logic [3:0] S_DONE      = 4'd10;
  localparam logic [3:0] S_ERR       = 4'd11;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_DIV  = 2'd1;
  localparam logic [1:0] ERR_DRP  = 2'd2;
  localparam logic [1:0] ERR_LOCK = 2'd3;

  // reg1 address per CLKOUTn; reg2 is always reg1 + 1
  localparam logic [5:0][6:0] CLKOUT_ADDR = {
    7'h06, 7'h10, 7'h0E, 7'h0C, 7'h0A, 7'h08
  };

  localparam logic [15:0] REG1_KEEP = 16'h1000;
  localparam logic [15:0] REG2_KEEP = 16'hFF00;

  // {edge, nocount, high[5:0], low[5:0]}
  function automatic logic [13:0] div_to_regs(
    input logic [6:0] d
  );
    logic [5:0] hi;
    logic [5:0] lo;
    hi = d[6:1];
    lo = 6'(d - {1'b0, d[6:1]});
    if (d == 7'd1) begin
      hi = 6'd1;
      lo = 6'd1;
    end
    return {d[0], d == 7'd1, hi, lo};
  endfunction

  function automatic logic [15:0] new_reg(
    input logic        reg2,
    input logic [6:0]  d,
    input logic [15:0] old
  );
    logic [13:0] f;
    f = div_to_regs(d);
    if (reg2)
      return (old & REG2_KEEP) | {8'h00, f[13], f[12], 6'h00};
    return (old & REG1_KEEP) | {4'h0, f[11:0]};
  endfunction

endpackage

// File: rtl/pll_drp_reconfig_drp_access.sv
// One DRP read-modify-write of a divider register,
// with a per-access drdy timeout.
module drp_access
  import pll_drp_pkg::*;
#(
  parameter int DRP_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [6:0]  addr_i,
  input  logic        reg2_i,
  input  logic [6:0]  div_i,
  output logic        done_o,
  output logic        tmo_o,
  output logic [6:0]  daddr_o,
  output logic [15:0] di_o,
  input  logic [15:0] dout_i,
  output logic        den_o,
  output logic        dwe_o,
  input  logic        drdy_i
);

  localparam int CW = $clog2(DRP_TIMEOUT + 1);

  logic [3:0]    phase_q;
  logic [CW-1:0] cnt_q;
  logic          reg2_q;
  logic [6:0]    div_q;
  logic [6:0]    daddr_q;
  logic [15:0]   di_q;
  logic          den_q;
  logic          dwe_q;
  logic          waiting;
  logic          expire;

  assign waiting = (phase_q == S_RD_WAIT) ||
                   (phase_q == S_WR_WAIT);
  // drdy in the den cycle is never looked at
  assign expire  = waiting && !drdy_i &&
                   (cnt_q == CW'(DRP_TIMEOUT - 1));
  assign done_o  = (phase_q == S_WR_WAIT) && drdy_i;
  assign tmo_o   = expire;
  assign daddr_o = daddr_q;
  assign di_o    = di_q;
  assign den_o   = den_q;
  assign dwe_o   = dwe_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= S_IDLE;
      cnt_q   <= '0;
      reg2_q  <= 1'b0;
      div_q   <= '0;
      daddr_q <= '0;
      di_q    <= '0;
      den_q   <= 1'b0;
      dwe_q   <= 1'b0;
    end else begin
      case (phase_q)
        S_IDLE: if (start_i) begin
          daddr_q <= addr_i;
          reg2_q  <= reg2_i;
          div_q   <= div_i;
          den_q   <= 1'b1;
          dwe_q   <= 1'b0;
          phase_q <= S_RD;
        end
        S_RD: begin
          den_q   <= 1'b0;
          cnt_q   <= CW'(1);
          phase_q <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (drdy_i) begin
            di_q    <= new_reg(reg2_q, div_q, dout_i);
            den_q   <= 1'b1;
            dwe_q   <= 1'b1;
            phase_q <= S_WR;
          end else if (expire) begin
            phase_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_WR: begin
          den_q   <= 1'b0;
          dwe_q   <= 1'b0;
          cnt_q   <= CW'(1);
          phase_q <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          if (drdy_i || expire)
            phase_q <= S_IDLE;
          else
            cnt_q <= cnt_q + CW'(1);
        end
        default: phase_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pll_drp_reconfig.sv
// Sequences CLKOUTn divider rewrites over DRP while the
// PLL is held in reset, then waits for lock.
module pll_drp_reconfig
  import pll_drp_pkg::*;
#(
  parameter int NUM_OUT      = 4,
  parameter int DRP_TIMEOUT  = 255,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int RST_HOLD     = 4
) (
  input  logic                 refclk,
  input  logic                 rst_n,
  input  logic                 req,
  input  logic [NUM_OUT-1:0]   cfg_en,
  input  logic [7*NUM_OUT-1:0] cfg_div,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [6:0]           daddr,
  output logic [15:0]          di,
  input  logic [15:0]          dout,
  output logic                 den,
  output logic                 dwe,
  input  logic                 drdy,
  output logic                 pll_rst,
  input  logic                 pll_locked
);

  localparam int HW = $clog2(RST_HOLD + 1);
  localparam int LW = $clog2(LOCK_TIMEOUT + 1);

  logic [3:0]           state_q, state_d;
  logic [NUM_OUT-1:0]   en_q, en_d;
  logic [7*NUM_OUT-1:0] div_q, div_d;
  logic [2:0]           ch_q, ch_d;
  logic                 reg2_q, reg2_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [LW-1:0]        lock_q, lock_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [1:0]           code_q, code_d;
  logic                 prst_q, prst_d;

  logic       start;
  logic       acc_done;
  logic       acc_tmo;
  logic [6:0] acc_addr;
  logic [6:0] sel_div;
  logic       bad_div;
  logic       nxt_found;
  logic [2:0] nxt_ch;
  int         base;

  // lowest enabled channel at or above base
  always_comb begin
    base      = (state_q == S_CHECK) ? 0 : int'(ch_q) + 1;
    nxt_found = 1'b0;
    nxt_ch    = '0;
    bad_div   = 1'b0;
    for (int i = NUM_OUT - 1; i >= 0; i--) begin
      if (en_q[i] && i >= base) begin
        nxt_found = 1'b1;
        nxt_ch    = 3'(i);
      end
      if (en_q[i] && div_q[7*i +: 7] == 7'd0)
        bad_div = 1'b1;
    end
  end

  always_comb begin
    sel_div = '0;
    for (int i = 0; i < NUM_OUT; i++)
      if (ch_d == 3'(i))
        sel_div = div_q[7*i +: 7];
  end

  assign acc_addr = {CLKOUT_ADDR[ch_d][6:1], reg2_d};

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    div_d   = div_q;
    ch_d    = ch_q;
    reg2_d  = reg2_q;
    hold_d  = hold_q;
    lock_d  = lock_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    prst_d  = prst_q;
    start   = 1'b0;
    case (state_q)
      S_IDLE: if (req) begin
        en_d    = cfg_en;
        div_d   = cfg_div;
        busy_d  = 1'b1;
        code_d  = ERR_NONE;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (bad_div) begin
          state_d = S_ERR;
          code_d  = ERR_DIV;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end else if (!nxt_found) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = S_HOLD;
          prst_d  = 1'b1;
          hold_d  = '0;
          ch_d    = nxt_ch;
          reg2_d  = 1'b0;
        end
      end
      S_HOLD: begin
        if (hold_q == HW'(RST_HOLD - 1)) begin
          start   = 1'b1;
          state_d = S_RD;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      // one full read-modify-write runs in drp_access
      S_RD: begin
        if (acc_done) begin
          state_d = S_NEXT;
        end else if (acc_tmo) begin
          state_d = S_ERR;
          code_d  = ERR_DRP;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          prst_d  = 1'b0;
        end
      end
      S_NEXT: begin
        if (!reg2_q) begin
          reg2_d  = 1'b1;
          start   = 1'b1;
          state_d = S_RD;
        end else if (nxt_found) begin
          ch_d    = nxt_ch;
          reg2_d  = 1'b0;
          start   = 1'b1;
          state_d = S_RD;
        end else begin
          prst_d  = 1'b0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        lock_d  = '0;
        state_d = S_LOCK_WAIT;
      end
      S_LOCK_WAIT: begin
        if (pll_locked) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (lock_q == LW'(LOCK_TIMEOUT - 1)) begin
          state_d = S_ERR;
          code_d  = ERR_LOCK;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end else begin
          lock_d = lock_q + LW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      en_q    <= '0;
      div_q   <= '0;
      ch_q    <= '0;
      reg2_q  <= 1'b0;
      hold_q  <= '0;
      lock_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      prst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      div_q   <= div_d;
      ch_q    <= ch_d;
      reg2_q  <= reg2_d;
      hold_q  <= hold_d;
      lock_q  <= lock_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
      prst_q  <= prst_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = code_q;
  assign pll_rst  = prst_q;

  drp_access #(
    .DRP_TIMEOUT(DRP_TIMEOUT)
  ) u_drp (
    .clk_i  (refclk),
    .rst_ni (rst_n),
    .start_i(start),
    .addr_i (acc_addr),
    .reg2_i (reg2_d),
    .div_i  (sel_div),
    .done_o (acc_done),
    .tmo_o  (acc_tmo),
    .daddr_o(daddr),
    .di_o   (di),
    .dout_i (dout),
    .den_o  (den),
    .dwe_o  (dwe),
    .drdy_i (drdy)
  );

endmodule

// File: tb/tb_pll_drp_reconfig.sv
// Directed bench for pll_drp_reconfig with a
// behavioural DRP port model.
module tb_pll_drp_reconfig;

  localparam int N  = 4;
  localparam int DT = 20;
  localparam int LT = 60;
  localparam int RH = 4;

  logic           refclk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req = 1'b0;
  logic [N-1:0]   cfg_en = '0;
  logic [7*N-1:0] cfg_div = '0;
  logic           busy, done, err;
  logic [1:0]     err_code;
  logic [6:0]     daddr;
  logic [15:0]    di;
  logic [15:0]    dout = '0;
  logic           den, dwe;
  logic           drdy = 1'b0;
  logic           pll_rst;
  logic           pll_locked = 1'b0;

  int checks = 0;
  int errors = 0;

  pll_drp_reconfig #(
    .NUM_OUT(N), .DRP_TIMEOUT(DT),
    .LOCK_TIMEOUT(LT), .RST_HOLD(RH)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .req(req),
    .cfg_en(cfg_en), .cfg_div(cfg_div),
    .busy(busy), .done(done), .err(err),
    .err_code(err_code), .daddr(daddr), .di(di),
    .dout(dout), .den(den), .dwe(dwe), .drdy(drdy),
    .pll_rst(pll_rst), .pll_locked(pll_locked)
  );

  always #5 refclk = ~refclk;

  // DRP model: drdy three cycles after den
  logic [15:0] preset_v = '0;
  logic        hang9 = 1'b0;
  logic        den_prev = 1'b0;
  logic [6:0]  p_addr = '0;
  int          lat, cyc, den_n, pr_n, wr_n;
  int          den_long, dwe_bad, den9_cyc;
  logic [6:0]  wa [64];
  logic [15:0] wd [64];

  always @(posedge refclk) begin
    cyc      <= cyc + 1;
    drdy     <= 1'b0;
    den_prev <= den;
    if (den && den_prev) den_long <= den_long + 1;
    if (dwe && !den) dwe_bad <= dwe_bad + 1;
    if (pll_rst) pr_n <= pr_n + 1;
    if (den) begin
      den_n  <= den_n + 1;
      p_addr <= daddr;
      lat    <= 3;
      if (daddr == 7'h09 && !dwe) den9_cyc <= cyc;
      if (dwe) begin
        wa[wr_n[5:0]] <= daddr;
        wd[wr_n[5:0]] <= di;
        wr_n <= wr_n + 1;
      end
    end else if (lat > 0) begin
      lat <= lat - 1;
      if (lat == 1 && !(hang9 && p_addr == 7'h09)) begin
        drdy <= 1'b1;
        dout <= preset_v;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [7*N-1:0] dv4(
    input int d0, input int d1, input int d2, input int d3);
    return {7'(d3), 7'(d2), 7'(d1), 7'(d0)};
  endfunction

  task automatic start(input logic [N-1:0] en,
                       input logic [7*N-1:0] dv);
    @(negedge refclk);
    cfg_en  = en;
    cfg_div = dv;
    req     = 1'b1;
    @(negedge refclk);
    req     = 1'b0;
  endtask

  // lmode 0: lock rises 2 cycles after release
  // lmode 1: lock drops at release and stays low
  task automatic run_wait(input int maxc, input int lmode,
                          input int exp_got,
                          output int ecyc, output int rcyc);
    logic prev;
    int   dly;
    int   got;
    got  = 0;
    ecyc = 0;
    rcyc = 0;
    dly  = -1;
    prev = pll_rst;
    for (int i = 0; i < maxc && got == 0; i++) begin
      @(negedge refclk);
      if (prev && !pll_rst) begin
        rcyc = cyc;
        if (lmode == 0) dly = 2;
        else pll_locked = 1'b0;
      end
      prev = pll_rst;
      if (dly == 0) pll_locked = 1'b1;
      if (dly >= 0) dly--;
      if (done) got = 1;
      else if (err) got = 2;
      if (got != 0) ecyc = cyc;
    end
    chk("outcome", got, exp_got);
    if (got != 0) begin
      chk("busy_at_pulse", busy, 0);
      @(negedge refclk);
      chk("pulse_fall", {done, err}, 0);
    end
  endtask

  task automatic chk_wr(input int b,
    input logic [6:0] a0, input logic [15:0] d0,
    input logic [6:0] a1, input logic [15:0] d1,
    input logic [6:0] a2, input logic [15:0] d2,
    input logic [6:0] a3, input logic [15:0] d3);
    logic [6:0]  ea [4];
    logic [15:0] ed [4];
    ea = '{a0, a1, a2, a3};
    ed = '{d0, d1, d2, d3};
    chk("wr_count", wr_n - b, 4);
    for (int i = 0; i < 4; i++) begin
      chk("wr_addr", wa[(b + i) % 64], ea[i]);
      chk("wr_data", wd[(b + i) % 64], ed[i]);
    end
  endtask

  initial begin
    int   b, ec, rc, dn, pn;
    logic found;

    repeat (3) @(negedge refclk);
    chk("reset_outs",
        {busy, done, err, err_code, daddr, di, den, dwe, pll_rst},
        0);
    rst_n = 1'b1;

    // basic: ch0=32, ch2=64
    preset_v = 16'h0000;
    b = wr_n;
    start(4'b0101, dv4(32, 0, 64, 0));
    chk("check_rst", pll_rst, 0);
    chk("check_busy", busy, 1);
    @(negedge refclk);
    chk("hold_rst", pll_rst, 1);
    run_wait(300, 0, 1, ec, rc);
    chk_wr(b, 7'h08, 16'h0410, 7'h09, 16'h0000,
              7'h0C, 16'h0820, 7'h0D, 16'h0000);
    chk("code_ok", err_code, 0);

    // div=1 on ch1, div=7 on ch3
    b = wr_n;
    start(4'b1010, dv4(0, 1, 0, 7));
    run_wait(300, 0, 1, ec, rc);
    chk_wr(b, 7'h0A, 16'h0041, 7'h0B, 16'h00C0,
              7'h0E, 16'h00C4, 7'h0F, 16'h0080);

    // keep masks with 0xFFFF preset
    preset_v = 16'hFFFF;
    b = wr_n;
    start(4'b1010, dv4(0, 1, 0, 7));
    run_wait(300, 0, 1, ec, rc);
    chk_wr(b, 7'h0A, 16'h1041, 7'h0B, 16'hFFC0,
              7'h0E, 16'h10C4, 7'h0F, 16'hFF80);
    preset_v = 16'h0000;

    // no channel enabled
    dn = den_n;
    pn = pr_n;
    start(4'b0000, dv4(5, 5, 5, 5));
    run_wait(50, 0, 1, ec, rc);
    chk("noen_den", den_n - dn, 0);
    chk("noen_rst", pr_n - pn, 0);

    // illegal divider
    dn = den_n;
    pn = pr_n;
    start(4'b0101, dv4(5, 0, 0, 0));
    run_wait(50, 0, 2, ec, rc);
    chk("div0_code", err_code, 1);
    chk("div0_den", den_n - dn, 0);
    chk("div0_rst", pr_n - pn, 0);

    // drdy never returns for 0x09
    hang9 = 1'b1;
    start(4'b0001, dv4(32, 0, 0, 0));
    run_wait(300, 0, 2, ec, rc);
    chk("drp_code", err_code, 2);
    chk("drp_tmo_time", ec - den9_cyc, DT);
    chk("drp_rst_low", pll_rst, 0);
    hang9 = 1'b0;

    // stale lock then no lock
    pll_locked = 1'b1;
    start(4'b0001, dv4(32, 0, 0, 0));
    run_wait(400, 1, 2, ec, rc);
    chk("lock_code", err_code, 3);
    chk("lock_tmo_time",
        32'((ec - rc) >= LT && (ec - rc) <= LT + 1), 1);
    pll_locked = 1'b0;

    // async reset during WR_WAIT
    start(4'b0101, dv4(32, 0, 64, 0));
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge refclk);
      if (den && dwe) found = 1'b1;
    end
    chk("wr_seen", found, 1);
    @(negedge refclk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs",
        {busy, done, err, err_code, daddr, di, den, dwe, pll_rst},
        0);
    @(negedge refclk);
    rst_n = 1'b1;
    repeat (6) @(negedge refclk);
    b = wr_n;
    start(4'b0101, dv4(32, 0, 64, 0));
    run_wait(300, 0, 1, ec, rc);
    chk_wr(b, 7'h08, 16'h0410, 7'h09, 16'h0000,
              7'h0C, 16'h0820, 7'h0D, 16'h0000);

    chk("den_single", den_long, 0);
    chk("dwe_with_den", dwe_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
